// File: rtl/uart_cmd_pkg.sv
// Shared types and widths for the UART command wrapper: the rx/tx state
// encodings and the command/byte sizes.
package uart_cmd_pkg;

  localparam int CMD_W  = 24;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    B_HIGH,
    B_MID,
    B_LOW,
    FULL
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_BUSY
  } tx_state_t;

endpackage

// File: rtl/uart_cmd_if.sv
// Consumer-side bus of the UART command wrapper: assembled command with its
// ready/release handshake, and the one-byte response request/completion.
interface uart_cmd_if;
  import uart_cmd_pkg::*;

  logic [CMD_W-1:0]  cmd;
  logic              cmd_rdy;
  logic              clr_cmd_rdy;
  logic              send_resp;
  logic [BYTE_W-1:0] resp_data;
  logic              resp_sent;

  modport master (
    input  cmd, cmd_rdy, resp_sent,
    output clr_cmd_rdy, send_resp, resp_data
  );

  modport slave (
    output cmd, cmd_rdy, resp_sent,
    input  clr_cmd_rdy, send_resp, resp_data
  );

endinterface

// File: rtl/inter_byte_timer.sv
// Counts idle cycles between bytes of one command; expired is asserted during
// the TIMEOUT_CYC-th enabled cycle after the last clear.
module inter_byte_timer #(
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int TO_W        = $clog2(TIMEOUT_CYC)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST_CNT = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  assign expired = en && (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || expired) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering in simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Assembles three UART bytes into a 24-bit command held until released, and
// forwards one-byte responses to the UART transmitter.
module uart_cmd_wrapper
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int TO_W        = $clog2(TIMEOUT_CYC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_rdy,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              clr_rx_rdy,
  output logic              trmt,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_done,
  uart_cmd_if.slave         cmd_bus
);

  rx_state_t         rx_state_q, rx_state_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic              cmd_rdy_q, cmd_rdy_d;

  tx_state_t         tx_state_q, tx_state_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              trmt_q, trmt_d;
  logic              resp_sent_q, resp_sent_d;

  logic byte_take;
  logic to_en;
  logic to_expired;

  // FULL applies back-pressure: the receiver keeps its byte until release.
  assign byte_take  = rx_rdy && (rx_state_q != FULL);
  assign clr_rx_rdy = byte_take;
  assign to_en      = (rx_state_q == B_MID) || (rx_state_q == B_LOW);

  inter_byte_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (to_en),
    .clr     (byte_take || !to_en),
    .expired (to_expired)
  );

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rx_state_d = rx_state_q;
    cmd_d      = cmd_q;
    unique case (rx_state_q)
      B_HIGH: begin
        if (byte_take) begin
          cmd_d[23:16] = rx_data;
          rx_state_d   = B_MID;
        end
      end
      B_MID: begin
        if (byte_take) begin
          cmd_d[15:8] = rx_data;
          rx_state_d  = B_LOW;
        end else if (to_expired) begin
          rx_state_d = B_HIGH;
        end
      end
      B_LOW: begin
        if (byte_take) begin
          cmd_d[7:0] = rx_data;
          rx_state_d = FULL;
        end else if (to_expired) begin
          rx_state_d = B_HIGH;
        end
      end
      FULL: begin
        if (cmd_bus.clr_cmd_rdy) rx_state_d = B_HIGH;
      end
      default: rx_state_d = B_HIGH;
    endcase
    cmd_rdy_d = (rx_state_q == FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= B_HIGH;
      cmd_q      <= '0;
      cmd_rdy_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      cmd_q      <= cmd_d;
      cmd_rdy_q  <= cmd_rdy_d;
    end
  end

  // A request while busy is dropped, leaving the in-flight byte untouched.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_data_d   = tx_data_q;
    trmt_d      = 1'b0;
    resp_sent_d = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (cmd_bus.send_resp) begin
          tx_data_d  = cmd_bus.resp_data;
          trmt_d     = 1'b1;
          tx_state_d = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (tx_done) begin
          resp_sent_d = 1'b1;
          tx_state_d  = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q  <= TX_IDLE;
      tx_data_q   <= '0;
      trmt_q      <= 1'b0;
      resp_sent_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_data_q   <= tx_data_d;
      trmt_q      <= trmt_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  assign cmd_bus.cmd       = cmd_q;
  assign cmd_bus.cmd_rdy   = cmd_rdy_q;
  assign cmd_bus.resp_sent = resp_sent_q;
  assign trmt              = trmt_q;
  assign tx_data           = tx_data_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed bench for uart_cmd_wrapper: a transaction-level model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_uart_cmd_wrapper;

  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       clr_rx_rdy;
  logic       trmt;
  logic [7:0] tx_data;
  logic       tx_done = 1'b0;

  uart_cmd_if bus ();

  uart_cmd_wrapper #(.TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_rx_rdy (clr_rx_rdy),
    .trmt       (trmt),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .cmd_bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_clr    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: bytes collected so far (3 = command held), idle cycles since the
  // last byte, and the pending transmit byte.
  int          m_cnt  = 0;
  int          m_idle = 0;
  logic [23:0] m_cmd  = '0;
  logic        m_rdy  = 1'b0;
  logic        m_busy = 1'b0;
  logic [7:0]  m_txd  = '0;
  logic        m_trmt = 1'b0;
  logic        m_sent = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_idle = 0; m_cmd = '0; m_rdy = 1'b0;
      m_busy = 1'b0; m_txd = '0; m_trmt = 1'b0; m_sent = 1'b0;
    end else begin
      logic held_before;
      held_before = (m_cnt == 3);
      if (rx_rdy && m_cnt != 3) begin
        m_cmd[23 - 8*m_cnt -: 8] = rx_data;
        m_cnt++;
        m_idle = 0;
      end else if (m_cnt == 3) begin
        if (bus.clr_cmd_rdy) m_cnt = 0;
      end else if (m_cnt != 0) begin
        m_idle++;
        if (m_idle == TO) begin
          m_cnt  = 0;
          m_idle = 0;
        end
      end
      m_rdy  = held_before;
      m_trmt = 1'b0;
      m_sent = 1'b0;
      if (!m_busy && bus.send_resp) begin
        m_txd  = bus.resp_data;
        m_trmt = 1'b1;
        m_busy = 1'b1;
      end else if (m_busy && tx_done) begin
        m_sent = 1'b1;
        m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    check("cmd",        bus.cmd,       m_cmd);
    check("cmd_rdy",    bus.cmd_rdy,   m_rdy);
    check("clr_rx_rdy", clr_rx_rdy,    rx_rdy && (m_cnt != 3));
    check("trmt",       trmt,          m_trmt);
    check("tx_data",    tx_data,       m_txd);
    check("resp_sent",  bus.resp_sent, m_sent);
    if (clr_rx_rdy) n_clr++;
  end

  // Called at a falling edge; returns at the falling edge after the capture.
  task automatic send_byte(input logic [7:0] b);
    logic got;
    got = 1'b0;
    rx_rdy  = 1'b1;
    rx_data = b;
    for (int i = 0; i < 50 && !got; i++) begin
      #1;
      if (clr_rx_rdy) got = 1'b1;
      @(negedge clk);
    end
    rx_rdy = 1'b0;
    check("rx_capture", got, 1'b1);
  endtask

  task automatic release_cmd();
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp   = 1'b0;
    bus.resp_data   = 8'h00;

    repeat (3) @(negedge clk);
    #1;
    check("rst_cmd",       bus.cmd,       24'h0);
    check("rst_cmd_rdy",   bus.cmd_rdy,   1'b0);
    check("rst_trmt",      trmt,          1'b0);
    check("rst_tx_data",   tx_data,       8'h00);
    check("rst_resp_sent", bus.resp_sent, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Basic assembly with gaps below the timeout.
    n_clr = 0;
    send_byte(8'h02); repeat (90) @(negedge clk);
    send_byte(8'h00); repeat (90) @(negedge clk);
    send_byte(8'h0D);
    #1 check("rdy_not_yet", bus.cmd_rdy, 1'b0);
    @(negedge clk);
    #1;
    check("cmd_02000d", bus.cmd,     24'h02000D);
    check("rdy_high",   bus.cmd_rdy, 1'b1);
    check("clr_pulses", n_clr,       3);

    // Back-pressure while the command is held.
    rx_rdy = 1'b1; rx_data = 8'h55;
    repeat (5) begin
      #1 check("bp_clr_rx", clr_rx_rdy, 1'b0);
      @(negedge clk);
    end
    release_cmd();
    #1;
    check("rel_clr_rx",  clr_rx_rdy,  1'b1);
    check("rel_rdy_lag", bus.cmd_rdy, 1'b1);
    @(negedge clk);
    rx_rdy = 1'b0;
    #1;
    check("cmd_55_high", bus.cmd,     24'h55000D);
    check("rdy_low",     bus.cmd_rdy, 1'b0);
    repeat (110) @(negedge clk);
    #1 check("to_keeps_cmd", bus.cmd, 24'h55000D);
    @(negedge clk);

    // Expiry exactly TO cycles after the last byte discards 0x04.
    send_byte(8'h04);
    repeat (TO) @(negedge clk);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    @(negedge clk);
    #1;
    check("cmd_010203", bus.cmd,     24'h010203);
    check("rdy_010203", bus.cmd_rdy, 1'b1);
    @(negedge clk);
    release_cmd();

    // A byte in the expiry cycle itself wins.
    send_byte(8'h11);
    repeat (TO - 1) @(negedge clk);
    send_byte(8'h22); send_byte(8'h33);
    @(negedge clk);
    #1;
    check("cmd_112233", bus.cmd,     24'h112233);
    check("rdy_112233", bus.cmd_rdy, 1'b1);
    @(negedge clk);

    // Release, new byte and response request in the same cycle.
    bus.clr_cmd_rdy = 1'b1;
    bus.send_resp   = 1'b1; bus.resp_data = 8'hA5;
    rx_rdy = 1'b1;          rx_data = 8'hDD;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp   = 1'b0;
    #1;
    check("trmt_a5",    trmt,       1'b1);
    check("txd_a5",     tx_data,    8'hA5);
    check("clr_rx_dd",  clr_rx_rdy, 1'b1);
    @(negedge clk);
    rx_rdy = 1'b0;
    #1;
    check("cmd_dd",     bus.cmd,    24'hDD2233);
    check("trmt_once",  trmt,       1'b0);
    bus.send_resp = 1'b1; bus.resp_data = 8'hEE;
    @(negedge clk);
    bus.send_resp = 1'b0;
    #1;
    check("busy_no_trmt", trmt,    1'b0);
    check("busy_keep_tx", tx_data, 8'hA5);
    repeat (3) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    #1 check("resp_sent_hi", bus.resp_sent, 1'b1);
    @(negedge clk);
    #1 check("resp_sent_lo", bus.resp_sent, 1'b0);
    repeat (110) @(negedge clk);

    // Reset mid-assembly and mid-transmit.
    send_byte(8'hA1); send_byte(8'hB2);
    bus.send_resp = 1'b1; bus.resp_data = 8'h5A;
    @(negedge clk);
    bus.send_resp = 1'b0;
    #1 check("trmt_5a", trmt, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_cmd",  bus.cmd,     24'h0);
    check("mid_rst_rdy",  bus.cmd_rdy, 1'b0);
    check("mid_rst_trmt", trmt,        1'b0);
    check("mid_rst_txd",  tx_data,     8'h00);
    @(negedge clk);
    rst = 1'b0;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    #1 check("no_sent_1", bus.resp_sent, 1'b0);
    @(negedge clk);
    #1 check("no_sent_2", bus.resp_sent, 1'b0);
    send_byte(8'hC3); send_byte(8'hD4); send_byte(8'hE5);
    @(negedge clk);
    #1;
    check("cmd_c3d4e5", bus.cmd,     24'hC3D4E5);
    check("rdy_c3d4e5", bus.cmd_rdy, 1'b1);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
